// File: rtl/shift_normalizer_pkg.sv
// Shared types and constants for the shift normalizer.
package shift_normalizer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} norm_state_t;

  localparam logic MODE_LEFT  = 1'b0;
  localparam logic MODE_RIGHT = 1'b1;

endpackage

// File: rtl/shift_normalizer_norm_stage.sv
// One search stage: if the top 'width_in' bits are all zero, shift them out.
module norm_stage #(
  parameter  int D_SIZE = 8,
  localparam int W_SIZE = $clog2(D_SIZE) + 1
) (
  input  logic [D_SIZE-1:0] val_in,
  input  logic [W_SIZE-1:0] width_in,
  output logic [D_SIZE-1:0] val_out,
  output logic              hit_out
);

  logic [D_SIZE-1:0] w_mask;

  // Mask selects the top 'width_in' bits of the working value.
  assign w_mask  = ~({D_SIZE{1'b1}} >> width_in);
  assign hit_out = ~|(val_in & w_mask);
  assign val_out = hit_out ? (val_in << width_in) : val_in;

endmodule

// File: rtl/shift_normalizer.sv
// Iterative normalizer: binary search for the leading (left mode) or trailing
// (right mode) set bit, one stage per cycle, returning value and shift count.
// Right mode reuses the left-mode datapath by bit-reversing in and out.
module shift_normalizer
  import shift_normalizer_pkg::*;
#(
  parameter  int D_SIZE = 8,
  localparam int S_SIZE = $clog2(D_SIZE)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [D_SIZE-1:0] x_in,
  input  logic              mode_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [D_SIZE-1:0] y_out,
  output logic [S_SIZE-1:0] s_out,
  output logic              zf_out
);

  norm_state_t       r_state, w_state_nxt;
  logic [D_SIZE-1:0] r_work;
  logic [S_SIZE-1:0] r_k, r_cnt, w_cnt_nxt;
  logic              r_mode, r_zero;
  logic [D_SIZE-1:0] w_x_rev, w_stage_val, w_fin_rev;
  logic [S_SIZE:0]   w_width;
  logic              w_hit, w_accept;

  assign w_accept = (r_state == IDLE) && valid_in && ready_out;

  // Bit reversal of the operand on capture and of the final value on output.
  for (genvar i = 0; i < D_SIZE; i++) begin : g_rev
    assign w_x_rev[i]   = x_in[D_SIZE-1-i];
    assign w_fin_rev[i] = w_stage_val[D_SIZE-1-i];
  end

  // Stage width 2**k comes from the registered index, so one stage suffices.
  assign w_width   = {{S_SIZE{1'b0}}, 1'b1} << r_k;
  assign w_cnt_nxt = r_cnt | (w_hit ? (S_SIZE'(1) << r_k) : '0);

  norm_stage #(.D_SIZE(D_SIZE)) u_stage (
    .val_in   (r_work),
    .width_in (w_width),
    .val_out  (w_stage_val),
    .hit_out  (w_hit)
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (r_k == '0) w_state_nxt = DONE;
      DONE:    if (ready_in) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; results load as the last stage resolves.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ready_out <= 1'b1;
      valid_out <= 1'b0;
      y_out     <= '0;
      s_out     <= '0;
      zf_out    <= 1'b0;
      r_work    <= '0;
      r_k       <= '0;
      r_cnt     <= '0;
      r_mode    <= MODE_LEFT;
      r_zero    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_work    <= (mode_in == MODE_RIGHT) ? w_x_rev : x_in;
          r_mode    <= mode_in;
          r_zero    <= (x_in == '0);
          r_cnt     <= '0;
          r_k       <= S_SIZE'(S_SIZE - 1);
          ready_out <= 1'b0;
        end
        RUN: begin
          r_work <= w_stage_val;
          r_cnt  <= w_cnt_nxt;
          r_k    <= r_k - 1'b1;
          if (r_k == '0) begin
            valid_out <= 1'b1;
            y_out     <= (r_mode == MODE_RIGHT) ? w_fin_rev : w_stage_val;
            s_out     <= w_cnt_nxt;
            zf_out    <= r_zero;
          end
        end
        DONE: if (ready_in) begin
          valid_out <= 1'b0;
          ready_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
